// File: rtl/mux_scan_pipe.sv
// N:1 tree multiplexer with valid-qualified sampling and an auto-scan channel sequencer.
// Define MUX_PIPE_EN to register every tree level (latency LOG2N); default is latency 1.
module mux_scan_pipe #(
    parameter int unsigned N      = 8,
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned DWELL  = 4,
    localparam int unsigned LOG2N = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] a,
    input  logic [LOG2N-1:0]   s,
    input  logic               mode,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    output logic [LOG2N-1:0]   out_ch
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    typedef enum logic {StDirect, StScan} state_e;

    state_e           state_q, state_d;
    logic [LOG2N-1:0] ch_q, ch_d, base_ch, sel_ch;
    logic [DW-1:0]    dwell_q, dwell_d, base_dw;

    // One tree level: pairs (2j, 2j+1) collapse into entry j; upper half is zeroed.
    function automatic logic [N*WIDTH-1:0] halve(input logic [N*WIDTH-1:0] d, input logic b);
        logic [N*WIDTH-1:0] r;
        r = '0;
        for (int j = 0; j < N / 2; j++) begin
            r[j*WIDTH +: WIDTH] = b ? d[(2*j+1)*WIDTH +: WIDTH] : d[2*j*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    // The edge that samples mode=1 from DIRECT already scans, starting at channel 0.
    always_comb begin
        state_d = mode ? StScan : StDirect;
        ch_d    = ch_q;
        dwell_d = dwell_q;
        base_ch = (state_q == StScan) ? ch_q : '0;
        base_dw = (state_q == StScan) ? dwell_q : '0;
        sel_ch  = s;
        if (mode) begin
            sel_ch  = base_ch;
            ch_d    = base_ch;
            dwell_d = base_dw;
            if (in_valid) begin
                if (base_dw == DWELL_LAST) begin
                    dwell_d = '0;
                    ch_d    = base_ch + 1'b1;
                end else begin
                    dwell_d = base_dw + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StDirect;
            ch_q    <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            dwell_q <= dwell_d;
        end
    end

    logic [N*WIDTH-WIDTH-1:0] unused_hi;

`ifdef MUX_PIPE_EN
    logic [N*WIDTH-1:0] src_dat   [LOG2N];
    logic [LOG2N-1:0]   src_idx   [LOG2N];
    logic               src_vld   [LOG2N];
    logic [N*WIDTH-1:0] stg_dat_q [LOG2N];
    logic [LOG2N-1:0]   stg_idx_q [LOG2N];
    logic               stg_vld_q [LOG2N];

    always_comb begin
        src_dat[0] = a;
        src_idx[0] = sel_ch;
        src_vld[0] = in_valid;
        for (int k = 1; k < LOG2N; k++) begin
            src_dat[k] = stg_dat_q[k-1];
            src_idx[k] = stg_idx_q[k-1];
            src_vld[k] = stg_vld_q[k-1];
        end
    end

    // Data and index only advance with a valid sample so the final stage holds its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LOG2N; k++) begin
                stg_dat_q[k] <= '0;
                stg_idx_q[k] <= '0;
                stg_vld_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < LOG2N; k++) begin
                stg_vld_q[k] <= src_vld[k];
                if (src_vld[k]) begin
                    stg_dat_q[k] <= halve(src_dat[k], src_idx[k][k]);
                    stg_idx_q[k] <= src_idx[k];
                end
            end
        end
    end

    assign out       = stg_dat_q[LOG2N-1][WIDTH-1:0];
    assign out_ch    = stg_idx_q[LOG2N-1];
    assign out_valid = stg_vld_q[LOG2N-1];
    assign unused_hi = stg_dat_q[LOG2N-1][N*WIDTH-1:WIDTH];
`else
    logic [N*WIDTH-1:0] tree;
    logic [WIDTH-1:0]   out_q;
    logic [LOG2N-1:0]   out_ch_q;
    logic               out_valid_q;

    always_comb begin
        tree = a;
        for (int k = 0; k < LOG2N; k++) begin
            tree = halve(tree, sel_ch[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_q    <= tree[WIDTH-1:0];
                out_ch_q <= sel_ch;
            end
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign unused_hi = tree[N*WIDTH-1:WIDTH];
`endif

endmodule

// File: tb/tb_mux_scan_pipe.sv
// Self-checking bench for mux_scan_pipe: directed tables, scan/toggle/reset sequences and
// randomized traffic against a queue-based reference model (8:1, 2:1 and 16:1 instances).
module tb_mux_scan_pipe;

    localparam int N     = 8;
    localparam int DWELL = 4;
`ifdef MUX_PIPE_EN
    localparam int LAT8  = 3;
    localparam int LAT16 = 4;
`else
    localparam int LAT8  = 1;
    localparam int LAT16 = 1;
`endif
    localparam int LAT2 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b1;
    logic [7:0]   a;
    logic [2:0]   s;
    logic         mode, in_valid;
    logic [0:0]   out8;
    logic         ov8;
    logic [2:0]   och8;
    logic [1:0]   a2 = 2'b10;
    logic [0:0]   s2, out2, och2;
    logic         iv2, ov2;
    logic [127:0] a16;
    logic [3:0]   s16, och16;
    logic [7:0]   out16;
    logic         iv16, ov16;

    mux_scan_pipe #(.N(8), .WIDTH(1), .DWELL(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a), .s(s), .mode(mode), .in_valid(in_valid),
        .out(out8), .out_valid(ov8), .out_ch(och8)
    );
    mux_scan_pipe #(.N(2), .WIDTH(1), .DWELL(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .a(a2), .s(s2), .mode(1'b0), .in_valid(iv2),
        .out(out2), .out_valid(ov2), .out_ch(och2)
    );
    mux_scan_pipe #(.N(16), .WIDTH(8), .DWELL(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .s(s16), .mode(1'b0), .in_valid(iv16),
        .out(out16), .out_valid(ov16), .out_ch(och16)
    );

    typedef struct {
        int         due;
        logic [7:0] d;
        int         ch;
    } item_t;

    typedef struct {
        logic [7:0] a;
        logic [2:0] s;
        logic       e;
    } vec_t;

    item_t      q8[$], q2[$], q16[$];
    int         obs_ch[$];
    logic       obs_d[$];
    logic [7:0] l8_d, l2_d, l16_d;
    int         l8_ch, l2_ch, l16_ch;
    int         m_ch, m_dw;
    logic       m_scan;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl[16];
    int         tog_exp[8] = '{5, 2, 2, 0, 0, 0, 0, 1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q8.delete(); q2.delete(); q16.delete();
        l8_d = 0; l2_d = 0; l16_d = 0;
        l8_ch = 0; l2_ch = 0; l16_ch = 0;
        m_scan = 0; m_ch = 0; m_dw = 0;
    endtask

    // Scan rule: entering scan restarts at channel 0; every DWELL accepted samples advance it.
    task automatic model_capture();
        int ch;
        if (mode) begin
            if (!m_scan) begin
                m_ch = 0;
                m_dw = 0;
            end
            ch = m_ch;
            if (in_valid) begin
                m_dw++;
                if (m_dw == DWELL) begin
                    m_dw = 0;
                    m_ch = (m_ch + 1) % N;
                end
            end
        end else begin
            ch = int'(s);
        end
        m_scan = mode;
        if (in_valid) q8.push_back(item_t'{cyc + LAT8, 8'(a[ch]), ch});
        if (iv2) q2.push_back(item_t'{cyc + LAT2, 8'(s2), int'(s2)});
        if (iv16) q16.push_back(item_t'{cyc + LAT16, 8'(s16), int'(s16)});
    endtask

    task automatic check_out();
        logic ev;
        ev = 1'b0;
        if (q8.size() > 0 && q8[0].due == cyc) begin
            ev = 1'b1; l8_d = q8[0].d; l8_ch = q8[0].ch; void'(q8.pop_front());
        end
        expect_eq("valid8", 32'(ov8), 32'(ev));
        expect_eq("out8", 32'(out8), 32'(l8_d));
        expect_eq("ch8", 32'(och8), l8_ch);
        if (ov8) begin
            obs_ch.push_back(int'(och8));
            obs_d.push_back(out8[0]);
        end
        ev = 1'b0;
        if (q2.size() > 0 && q2[0].due == cyc) begin
            ev = 1'b1; l2_d = q2[0].d; l2_ch = q2[0].ch; void'(q2.pop_front());
        end
        expect_eq("valid2", 32'(ov2), 32'(ev));
        expect_eq("out2", 32'(out2), 32'(l2_d));
        expect_eq("ch2", 32'(och2), l2_ch);
        ev = 1'b0;
        if (q16.size() > 0 && q16[0].due == cyc) begin
            ev = 1'b1; l16_d = q16[0].d; l16_ch = q16[0].ch; void'(q16.pop_front());
        end
        expect_eq("valid16", 32'(ov16), 32'(ev));
        expect_eq("out16", 32'(out16), 32'(l16_d));
        expect_eq("ch16", 32'(och16), l16_ch);
    endtask

    task automatic step();
        model_capture();
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        a = '0; s = '0; mode = 1'b0; in_valid = 1'b0;
        iv2 = 1'b0; s2 = '0; iv16 = 1'b0; s16 = '0;
        for (int i = 0; i < 16; i++) a16[i*8 +: 8] = 8'(i);
        for (int i = 0; i < 8; i++) begin
            tbl[i]     = '{8'(1 << i), 3'(i), 1'b1};
            tbl[i + 8] = '{~8'(1 << i), 3'(i), 1'b0};
        end
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        expect_eq("rst_out", 32'(out8), 0);
        expect_eq("rst_valid", 32'(ov8), 0);
        expect_eq("rst_ch", 32'(och8), 0);
        expect_eq("rst_out16", 32'(out16), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Direct walk, one-hot then inverted one-hot
        for (int i = 0; i < 16; i++) begin
            a = tbl[i].a; s = tbl[i].s; in_valid = 1'b1;
            step();
            idle(LAT8);
            expect_eq("walk_out", 32'(out8), 32'(tbl[i].e));
            expect_eq("walk_ch", 32'(och8), 32'(tbl[i].s));
        end

        // Continuous scan over a = 10101010
        mode = 1'b0; idle(1);
        obs_ch.delete(); obs_d.delete();
        a = 8'hAA; mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) step();
        idle(5);
        expect_eq("scan_count", obs_ch.size(), 40);
        for (int i = 0; i < obs_ch.size() && i < 40; i++) begin
            expect_eq("scan_ch", obs_ch[i], (i / 4) % 8);
            expect_eq("scan_d", 32'(obs_d[i]), ((i / 4) % 8) & 1);
        end

        // Gapped strobe: still four samples per channel
        mode = 1'b0; idle(1);
        obs_ch.delete(); obs_d.delete();
        mode = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_valid = (i % 2 == 0);
            step();
        end
        idle(5);
        expect_eq("gap_count", obs_ch.size(), 32);
        for (int i = 0; i < obs_ch.size() && i < 32; i++) expect_eq("gap_ch", obs_ch[i], i / 4);

        // Mode toggle mid-scan without flushing
        mode = 1'b0; idle(1);
        mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) step();
        idle(5);
        obs_ch.delete(); obs_d.delete();
        in_valid = 1'b1; step();
        mode = 1'b0; s = 3'd2; step(); step();
        mode = 1'b1;
        for (int i = 0; i < 5; i++) step();
        idle(5);
        expect_eq("tog_count", obs_ch.size(), 8);
        for (int i = 0; i < obs_ch.size() && i < 8; i++) expect_eq("tog_ch", obs_ch[i], tog_exp[i]);

        // Reset with samples in flight
        mode = 1'b0; a = 8'hFF; s = 3'd3; in_valid = 1'b1;
        step(); step(); step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        expect_eq("mrst_out", 32'(out8), 0);
        expect_eq("mrst_valid", 32'(ov8), 0);
        expect_eq("mrst_ch", 32'(och8), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        obs_ch.delete(); obs_d.delete();
        idle(6);
        expect_eq("mrst_quiet", obs_ch.size(), 0);
        s = 3'd6; a = 8'h40; in_valid = 1'b1; step();
        idle(LAT8 + 1);
        expect_eq("mrst_new", obs_ch.size(), 1);

        // Randomized traffic on all three instances
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) mode = ~mode;
            in_valid = 1'($urandom);
            a = 8'($urandom);
            s = 3'($urandom);
            iv2 = 1'($urandom); s2 = 1'($urandom);
            iv16 = 1'($urandom); s16 = 4'($urandom);
            step();
        end
        iv2 = 1'b0; iv16 = 1'b0;
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
